uart_dbg_master: RTL and testbench

UART_DBG_MASTER -- requirements
Module: uart_dbg_master

---
 rtl/uart_dbg_master.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_dbg_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dbg_master.sv
// UART-to-AHB-lite debug master: receives read/write command packets over a
// parity-protected UART link, issues one single-word AHB transfer, and replies.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module uart_dbg_master #(
  parameter int BPS_115200   = 434,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RX,
  output logic                   TX,
  output logic [`WORD_WIDTH-1:0] HADDR,
  output logic [1:0]             HTRANS,
  output logic                   HWRITE,
  output logic [2:0]             HSIZE,
  output logic [2:0]             HBURST,
  output logic                   HMASTLOCK,
  output logic [`WORD_WIDTH-1:0] HWDATA,
  input  logic [`WORD_WIDTH-1:0] HRDATA,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic                   busy
);
  localparam int W  = `WORD_WIDTH;
  localparam int CW = $clog2(BPS_115200 + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BPS_115200 - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BPS_115200 / 2 - 1);
  localparam int TO_CYC = TIMEOUT_BITS * BPS_115200;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX_ADDR  = 3'd1;
  localparam logic [2:0] S_RX_DATA  = 3'd2;
  localparam logic [2:0] S_BUS_ADDR = 3'd3;
  localparam logic [2:0] S_BUS_DATA = 3'd4;
  localparam logic [2:0] S_TX_RESP  = 3'd5;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_BITS  = 2'd2;

  // Receiver. Sync flops reset low so a line held low after reset never
  // looks like a start edge until it has first gone high.
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]    rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [9:0]    rx_shift_q;
  logic          rx_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b0;
      rx_sync_q  <= 1'b0;
      rx_prev_q  <= 1'b0;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        R_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? R_IDLE : R_BITS;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        R_BITS: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[9:1]};
            if (rx_bit_q == 4'd9) begin
              rx_state_q <= R_IDLE;
              rx_valid_q <= 1'b1;
            end else begin
              rx_bit_q <= rx_bit_q + 4'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) rx_state_q <= R_START;
        end
      endcase
    end
  end

  logic [7:0] rx_byte;
  logic       rx_bad;
  assign rx_byte = rx_shift_q[7:0];
  assign rx_bad  = (^rx_shift_q[8:0]) | ~rx_shift_q[9];

  // Main packet / bus / response FSM.
  logic [2:0]    state_q;
  logic          is_write_q;
  logic [1:0]    byte_cnt_q;
  logic [W-1:0]  addr_sh_q, data_sh_q, haddr_q, hwdata_q;
  logic          hwrite_q;
  logic [W+7:0]  resp_q;
  logic [2:0]    resp_left_q;
  logic          tx_active_q;
  logic [10:0]   tx_frame_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [TW-1:0] to_cnt_q;

  logic [W-1:0] addr_nxt, data_nxt;
  logic [10:0]  next_frame;
  assign addr_nxt   = {rx_byte, addr_sh_q[W-1:8]};
  assign data_nxt   = {rx_byte, data_sh_q[W-1:8]};
  assign next_frame = {1'b1, ^resp_q[7:0], resp_q[7:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst || !(state_q == S_RX_ADDR || state_q == S_RX_DATA) || rx_state_q == R_BITS)
      to_cnt_q <= '0;
    else
      to_cnt_q <= to_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      hwrite_q    <= 1'b0;
      resp_q      <= '0;
      resp_left_q <= '0;
      tx_active_q <= 1'b0;
      tx_frame_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid_q && !rx_bad && (rx_byte == 8'h57 || rx_byte == 8'h52)) begin
            is_write_q <= (rx_byte == 8'h57);
            byte_cnt_q <= '0;
            state_q    <= S_RX_ADDR;
          end
        end
        S_RX_ADDR: begin
          if (rx_valid_q) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            addr_sh_q  <= addr_nxt;
            if (rx_bad) begin
              resp_q <= {{W{1'b0}}, 8'h15}; resp_left_q <= 3'd1; state_q <= S_TX_RESP;
            end else if (byte_cnt_q == 2'd3) begin
              if (is_write_q) begin
                state_q <= S_RX_DATA;
              end else if (addr_nxt[1:0] != 2'b00) begin
                resp_q <= {{W{1'b0}}, 8'h15}; resp_left_q <= 3'd1; state_q <= S_TX_RESP;
              end else begin
                haddr_q <= addr_nxt; hwrite_q <= 1'b0; state_q <= S_BUS_ADDR;
              end
            end
          end else if (to_cnt_q == TO_LAST) begin
            state_q <= S_IDLE;
          end
        end
        S_RX_DATA: begin
          if (rx_valid_q) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            data_sh_q  <= data_nxt;
            // Alignment is judged only once the whole write packet is in, so
            // trailing data bytes are never mistaken for a new command.
            if (rx_bad || (byte_cnt_q == 2'd3 && addr_sh_q[1:0] != 2'b00)) begin
              resp_q <= {{W{1'b0}}, 8'h15}; resp_left_q <= 3'd1; state_q <= S_TX_RESP;
            end else if (byte_cnt_q == 2'd3) begin
              haddr_q  <= addr_sh_q;
              hwdata_q <= data_nxt;
              hwrite_q <= 1'b1;
              state_q  <= S_BUS_ADDR;
            end
          end else if (to_cnt_q == TO_LAST) begin
            state_q <= S_IDLE;
          end
        end
        S_BUS_ADDR: begin
          if (HREADY) state_q <= S_BUS_DATA;
        end
        S_BUS_DATA: begin
          if (HREADY) begin
            hwrite_q    <= 1'b0;
            tx_active_q <= 1'b0;
            state_q     <= S_TX_RESP;
            if (HRESP != 2'b00) begin
              resp_q <= {{W{1'b0}}, 8'h15}; resp_left_q <= 3'd1;
            end else if (is_write_q) begin
              resp_q <= {{W{1'b0}}, 8'h06}; resp_left_q <= 3'd1;
            end else begin
              resp_q <= {HRDATA, 8'h06}; resp_left_q <= 3'd5;
            end
          end
        end
        S_TX_RESP: begin
          // Next frame is loaded on the final stop-bit cycle, so bytes leave back-to-back.
          if (!tx_active_q || (tx_cnt_q == BIT_LAST && tx_bit_q == 4'd10 && resp_left_q != 3'd0)) begin
            tx_frame_q  <= next_frame;
            resp_q      <= resp_q >> 8;
            resp_left_q <= resp_left_q - 3'd1;
            tx_active_q <= 1'b1;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
          end else if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd10) begin
              tx_active_q <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              tx_frame_q <= {1'b1, tx_frame_q[10:1]};
              tx_bit_q   <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign TX        = tx_active_q ? tx_frame_q[0] : 1'b1;
  assign busy      = (state_q != S_IDLE);
  assign HTRANS    = (state_q == S_BUS_ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = haddr_q;
  assign HWDATA    = hwdata_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
endmodule

// File: tb/tb_uart_dbg_master.sv
// Directed bench for uart_dbg_master: UART driver, AHB slave model, and
// scoreboards for expected TX bytes and expected bus transfers.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_uart_dbg_master;
  localparam int BPS = 32;

  logic        clk = 1'b0;
  logic        rst, RX, TX, HWRITE, HMASTLOCK, HREADY, busy;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HSIZE, HBURST;

  uart_dbg_master #(.BPS_115200(BPS), .TIMEOUT_BITS(16)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] b; logic contig; } tx_t;
  typedef struct packed { logic [31:0] addr; logic wr; logic [31:0] wdata; } bus_t;

  tx_t  tx_exp[$];
  bus_t bus_exp[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, nonseq_cnt = 0, exp_nonseq = 0;
  int   ws_cfg = 0;
  logic [1:0] resp_cfg = 2'b00;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AHB slave: optional wait states and response code on the data phase.
  initial begin
    logic in_data, addr_acc;
    int   ws_cnt;
    in_data = 0; addr_acc = 0; ws_cnt = 0;
    HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h12345678;
    forever begin
      @(posedge clk); #1;
      if (in_data && HREADY) in_data = 0;
      if (addr_acc) begin in_data = 1; ws_cnt = ws_cfg; end
      if (in_data) begin
        HREADY = (ws_cnt == 0);
        if (ws_cnt > 0) ws_cnt--;
        HRESP = HREADY ? resp_cfg : 2'b00;
      end else begin
        HREADY = 1'b1; HRESP = 2'b00;
      end
      addr_acc = (HTRANS === 2'b10) && HREADY;
    end
  end

  // Bus monitor: each completed address phase must match the next expected transfer.
  bus_t cur;
  logic mon_data = 1'b0;
  always @(negedge clk) begin
    if (mon_data && HREADY === 1'b1) begin
      check("data_haddr", 64'(HADDR), 64'(cur.addr));
      if (cur.wr) check("hwdata", 64'(HWDATA), 64'(cur.wdata));
      mon_data = 1'b0;
    end
    if (HTRANS === 2'b10 && HREADY === 1'b1) begin
      nonseq_cnt++;
      vectors++;
      assert (bus_exp.size() != 0) else begin
        miscompares++;
        $error("FAIL bus_unexpected: observed NONSEQ at %0h expected none", HADDR);
      end
      if (bus_exp.size() != 0) begin
        cur = bus_exp.pop_front();
        check("haddr", 64'(HADDR), 64'(cur.addr));
        check("hwrite", 64'(HWRITE), 64'(cur.wr));
        mon_data = 1'b1;
      end
    end
  end

  // TX monitor: decode each frame, compare with the scoreboard, and check
  // that bytes of one response start exactly 11 bit periods apart.
  initial begin
    logic [9:0] bits;
    logic       aborted;
    int         st, last_st;
    tx_t        e;
    last_st = 0;
    forever begin
      @(negedge TX);
      st = cyc; aborted = 0;
      repeat (BPS / 2) begin @(negedge clk); if (rst) aborted = 1; end
      for (int i = 0; i < 10; i++) begin
        for (int j = 0; j < BPS; j++) begin @(negedge clk); if (rst) aborted = 1; end
        bits[i] = TX;
      end
      if (!aborted) begin
        vectors++;
        assert (tx_exp.size() != 0) else begin
          miscompares++;
          $error("FAIL tx_unexpected: observed byte %0h expected none", bits[7:0]);
        end
        if (tx_exp.size() != 0) begin
          e = tx_exp.pop_front();
          check("tx_frame", 64'(bits), 64'({1'b1, ^e.b, e.b}));
          if (e.contig) check("tx_gap", 64'(st - last_st), 64'(11 * BPS));
        end
        last_st = st;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic bad);
    logic [10:0] fr;
    fr = {1'b1, (^b) ^ bad, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      RX = fr[i];
      repeat (BPS) @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_tx(input logic [7:0] b, input logic contig);
    tx_t e;
    e.b = b; e.contig = contig;
    tx_exp.push_back(e);
  endtask

  task automatic expect_bus(input logic [31:0] a, input logic wr, input logic [31:0] d);
    bus_t t;
    t.addr = a; t.wr = wr; t.wdata = d;
    bus_exp.push_back(t);
    exp_nonseq++;
  endtask

  task automatic finish_txn(input string tag);
    for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
    repeat (2 * BPS) @(negedge clk);
    check({tag, "_tx_left"}, 64'(tx_exp.size()), 64'(0));
    check({tag, "_bus_left"}, 64'(bus_exp.size()), 64'(0));
    check({tag, "_nonseq"}, 64'(nonseq_cnt), 64'(exp_nonseq));
    $display("txn %s done: nonseq=%0d", tag, nonseq_cnt);
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; RX = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 64'(TX), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_htrans", 64'(HTRANS), 64'(0));
    check("rst_hwrite", 64'(HWRITE), 64'(0));
    check("rst_haddr", 64'(HADDR), 64'(0));
    check("rst_hwdata", 64'(HWDATA), 64'(0));
    check("const_ctrl", 64'({HSIZE, HBURST, HMASTLOCK}), 64'({3'b010, 3'b000, 1'b0}));
    rst = 1'b0;
    repeat (2 * BPS) @(posedge clk);

    // Write OKAY.
    expect_bus(32'h20001000, 1'b1, 32'hDEADBEEF);
    expect_tx(8'h06, 1'b0);
    send_byte(8'h57, 1'b0);
    check("wr_busy_start", 64'(busy), 64'(1));
    send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h20, 1'b0);
    send_byte(8'hEF, 1'b0); send_byte(8'hBE, 1'b0); send_byte(8'hAD, 1'b0); send_byte(8'hDE, 1'b0);
    finish_txn("write");

    // Read with three data-phase wait states.
    ws_cfg = 3;
    expect_bus(32'h00000004, 1'b0, 32'h0);
    expect_tx(8'h06, 1'b0); expect_tx(8'h78, 1'b1); expect_tx(8'h56, 1'b1);
    expect_tx(8'h34, 1'b1); expect_tx(8'h12, 1'b1);
    send_byte(8'h52, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    finish_txn("read_ws");
    ws_cfg = 0;

    // Bad parity on address byte 2.
    expect_tx(8'h15, 1'b0);
    send_byte(8'h52, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    finish_txn("bad_parity");

    // Misaligned address.
    expect_tx(8'h15, 1'b0);
    send_byte(8'h52, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    finish_txn("misaligned");

    // Slave error on a write.
    resp_cfg = 2'b01;
    expect_bus(32'h00000100, 1'b1, 32'hCAFEF00D);
    expect_tx(8'h15, 1'b0);
    send_byte(8'h57, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h0D, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'hFE, 1'b0); send_byte(8'hCA, 1'b0);
    finish_txn("hresp_err");
    resp_cfg = 2'b00;

    // Short low glitch, then an unknown command byte.
    @(posedge clk); #1; RX = 1'b0;
    repeat (10) @(posedge clk);
    #1; RX = 1'b1;
    repeat (12 * BPS) @(negedge clk);
    check("glitch_busy", 64'(busy), 64'(0));
    send_byte(8'hAA, 1'b0);
    check("badcmd_busy", 64'(busy), 64'(0));
    finish_txn("noise");

    // Inter-byte timeout.
    send_byte(8'h57, 1'b0); send_byte(8'h00, 1'b0);
    repeat (14 * BPS) @(negedge clk);
    check("to_busy_before", 64'(busy), 64'(1));
    repeat (3 * BPS) @(negedge clk);
    check("to_busy_after", 64'(busy), 64'(0));
    finish_txn("timeout");

    // Reset in the middle of a read response.
    expect_bus(32'h00000008, 1'b0, 32'h0);
    expect_tx(8'h06, 1'b0);
    send_byte(8'h52, 1'b0); send_byte(8'h08, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    for (int i = 0; i < 2000 && TX; i++) @(negedge clk);
    check("rstresp_start", 64'(TX), 64'(0));
    repeat (16 * BPS) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    check("rstresp_tx", 64'(TX), 64'(1));
    check("rstresp_busy", 64'(busy), 64'(0));
    check("rstresp_htrans", 64'(HTRANS), 64'(0));
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    finish_txn("reset_resp");

    // Recovery after reset: plain read.
    expect_bus(32'h0000000C, 1'b0, 32'h0);
    expect_tx(8'h06, 1'b0); expect_tx(8'h78, 1'b1); expect_tx(8'h56, 1'b1);
    expect_tx(8'h34, 1'b1); expect_tx(8'h12, 1'b1);
    send_byte(8'h52, 1'b0); send_byte(8'h0C, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    finish_txn("read_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
